// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage in-order pipeline: RAW scoreboard,
// memory-wait FSM, redirect flush and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_en_rd,
    input  logic [4:0]        id_rd,
    input  logic              wb_valid,
    input  logic              wb_en_rd,
    input  logic [4:0]        wb_rd,
    input  logic              mem_req,
    input  logic              mem_done,
    input  logic              ex_redirect,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              stall_wb,
    output logic              bubble_ex,
    output logic              bubble_wb,
    output logic              flush_id,
    output logic              busy_any,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] cnt [NREG];

    logic mem_stall;
    logic rs1_busy;
    logic rs2_busy;
    logic raw;
    logic issue;
    logic inc;
    logic dec;
    logic busy;

    // Memory wait FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (mem_req && !mem_done) begin
                    state_nxt = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_nxt = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    // RAW check against the in-flight writer counts; x0 never blocks.
    assign rs1_busy = id_use_rs1 && (id_rs1 != 5'd0) && (cnt[id_rs1] != '0);
    assign rs2_busy = id_use_rs2 && (id_rs2 != 5'd0) && (cnt[id_rs2] != '0);
    assign raw      = id_valid && (rs1_busy || rs2_busy);

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy = busy | (cnt[i] != '0);
        end
    end

    // Control outputs, priority mem_stall > redirect > raw > issue.
    always_comb begin
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        flush_id  = 1'b0;
        busy_any  = 1'b0;
        issue     = 1'b0;
        if (reset) begin
            busy_any = busy;
            if (mem_stall) begin
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (ex_redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (raw) begin
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end else begin
                issue = id_valid;
            end
        end
    end

    assign inc = issue && id_en_rd && (id_rd != 5'd0);
    assign dec = wb_valid && wb_en_rd && (wb_rd != 5'd0);

    // Scoreboard: simultaneous inc/dec on one register cancels out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (inc && (id_rd == 5'(i)) && !(dec && (wb_rd == 5'(i)))) begin
                    assert (cnt[i] != CNT_MAX);
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else if (dec && (wb_rd == 5'(i)) && !(inc && (id_rd == 5'(i)))) begin
                    if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall_id && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each task drives a scenario cycle by cycle
// and compares the control outputs against hand-computed vectors.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_en_rd;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        wb_valid, wb_en_rd;
    logic [4:0]  wb_rd;
    logic        mem_req, mem_done, ex_redirect;
    logic        stall_id, stall_ex, stall_mem, stall_wb;
    logic        bubble_ex, bubble_wb, flush_id, busy_any;
    logic [31:0] stall_cycles;
    logic [7:0]  ctl;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.NREG(32), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_en_rd(id_en_rd), .id_rd(id_rd),
        .wb_valid(wb_valid), .wb_en_rd(wb_en_rd), .wb_rd(wb_rd),
        .mem_req(mem_req), .mem_done(mem_done), .ex_redirect(ex_redirect),
        .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb), .flush_id(flush_id),
        .busy_any(busy_any), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // {stall_id, stall_ex, stall_mem, stall_wb, bubble_ex, bubble_wb, flush_id, busy_any}
    assign ctl = {stall_id, stall_ex, stall_mem, stall_wb, bubble_ex, bubble_wb, flush_id, busy_any};

    task automatic clear_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_en_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_valid = 0; wb_en_rd = 0; wb_rd = 0;
        mem_req = 0; mem_done = 0; ex_redirect = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        id_valid = 1; id_en_rd = 1; id_rd = rd;
    endtask

    task automatic wb_wr(input logic [4:0] rd);
        wb_valid = 1; wb_en_rd = 1; wb_rd = rd;
    endtask

    task automatic read_rs1(input logic [4:0] rs);
        id_valid = 1; id_use_rs1 = 1; id_rs1 = rs;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        mem_req = 1; ex_redirect = 1; read_rs1(5'd1);
        #4;
        n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'b0); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_perf got=%0d exp=0", stall_cycles); end
        next_cycle();
        reset = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b0) begin n_bad++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, 8'b0); end
        next_cycle();
    endtask

    task automatic test_raw();
        issue_wr(5'd5);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL raw_issue got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            read_rs1(5'd5);
            if (c == 3) wb_wr(5'd5);
            @(negedge clk);
            n_cmp++; if (ctl !== 8'b10001001) begin n_bad++; $display("FAIL raw_stall_c%0d got=%b exp=%b", c, ctl, 8'b10001001); end
            next_cycle();
        end
        read_rs1(5'd5);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL raw_release got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL raw_perf got=%0d exp=3", stall_cycles); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        issue_wr(5'd7);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL b2b_first got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        issue_wr(5'd7);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL b2b_second got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL b2b_cnt2 got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        wb_wr(5'd7);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL b2b_wb1 got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        wb_wr(5'd7); read_rs1(5'd7);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b10001001) begin n_bad++; $display("FAIL b2b_cnt1_stall got=%b exp=%b", ctl, 8'b10001001); end
        next_cycle();
        read_rs1(5'd7);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL b2b_drained got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd4) begin n_bad++; $display("FAIL b2b_perf got=%0d exp=4", stall_cycles); end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 4; c++) begin
            mem_req = 1; issue_wr(5'd12);
            if (c == 2) ex_redirect = 1;
            @(negedge clk);
            n_cmp++; if (ctl !== 8'b11100100) begin n_bad++; $display("FAIL mem_stall_c%0d got=%b exp=%b", c, ctl, 8'b11100100); end
            next_cycle();
        end
        mem_req = 1; mem_done = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL mem_done got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL mem_back_idle got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd8) begin n_bad++; $display("FAIL mem_perf got=%0d exp=8", stall_cycles); end
        next_cycle();
        mem_req = 1; mem_done = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL mem_zero_wait got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL mem_zero_wait_after got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
    endtask

    task automatic test_redirect();
        issue_wr(5'd3);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL redir_setup got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        ex_redirect = 1; read_rs1(5'd3); id_en_rd = 1; id_rd = 5'd10;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00001011) begin n_bad++; $display("FAIL redir_flush got=%b exp=%b", ctl, 8'b00001011); end
        next_cycle();
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd10;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL redir_no_issue got=%b exp=%b", ctl, 8'b00000001); end
        n_cmp++; if (stall_cycles !== 32'd8) begin n_bad++; $display("FAIL redir_perf got=%0d exp=8", stall_cycles); end
        next_cycle();
        wb_wr(5'd3);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL redir_wb got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL redir_unchanged got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
    endtask

    task automatic test_same_reg();
        issue_wr(5'd9);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL same_setup got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
        issue_wr(5'd9); wb_wr(5'd9);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL same_incdec got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        read_rs1(5'd0); id_rs2 = 5'd9;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL same_x0_read got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd9;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b10001001) begin n_bad++; $display("FAIL same_still_one got=%b exp=%b", ctl, 8'b10001001); end
        next_cycle();
        wb_wr(5'd9);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL same_wb got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL same_drained got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd9) begin n_bad++; $display("FAIL same_perf got=%0d exp=9", stall_cycles); end
        next_cycle();
    endtask

    task automatic test_reset_wait();
        issue_wr(5'd4);
        next_cycle();
        issue_wr(5'd4);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000001) begin n_bad++; $display("FAIL rstw_setup got=%b exp=%b", ctl, 8'b00000001); end
        next_cycle();
        mem_req = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b11100101) begin n_bad++; $display("FAIL rstw_enter got=%b exp=%b", ctl, 8'b11100101); end
        next_cycle();
        mem_req = 1;
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b11100101) begin n_bad++; $display("FAIL rstw_waiting got=%b exp=%b", ctl, 8'b11100101); end
        reset = 0;
        #1;
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL rstw_async_ctl got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstw_async_perf got=%0d exp=0", stall_cycles); end
        next_cycle();
        reset = 1;
        read_rs1(5'd4);
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL rstw_after got=%b exp=%b", ctl, 8'b00000000); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstw_after_perf got=%0d exp=0", stall_cycles); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (ctl !== 8'b00000000) begin n_bad++; $display("FAIL rstw_idle got=%b exp=%b", ctl, 8'b00000000); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_back_to_back();
        test_mem_wait();
        test_redirect();
        test_same_reg();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush generator for the 5-stage in-order pipeline.
- Drives the stall and bubble inputs of the ID, EX, MEM and WB pipeline registers.
- Per-register scoreboard of in-flight writers gives RAW interlock (no forwarding).
- Also handles multi-cycle memory waits and EX-resolved redirects; keeps a stall-cycle performance counter.

Parameters:
NREG, 32, architectural registers (x0 hardwired zero)
CNT_W, 2, width of per-register in-flight writer counter
PERF_W, 32, width of stall-cycle counter

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
id_rs1, id_rs2  in  5  ID source register indices
id_en_rd, id_rd  in  1, 5  ID instruction writes rd
wb_valid, wb_en_rd, wb_rd  in  1, 1, 5  WB stage writes rd at the coming edge
mem_req  in  1  MEM stage holds a load/store needing memory
mem_done  in  1  memory response this cycle
ex_redirect  in  1  EX resolved a taken branch/jump
stall_id, stall_ex, stall_mem, stall_wb  out  1  hold the corresponding pipeline register
bubble_ex  out  1  EX register loads NOP instead of ID output
bubble_wb  out  1  WB register loads NOP instead of MEM output
flush_id  out  1  ID register loads NOP (discard fetched instruction)
busy_any  out  1  any scoreboard counter nonzero
stall_cycles  out  PERF_W  cycles with stall_id=1, saturating

Behaviour:
- Memory FSM, states IDLE/WAIT, registered:
  - IDLE->WAIT on mem_req & ~mem_done.
  - WAIT->IDLE on mem_done.
  - mem_stall = (IDLE & mem_req & ~mem_done) | (WAIT & ~mem_done).
  - mem_done in IDLE with mem_req gives zero-wait completion, no stall.
- RAW check:
  - raw = id_valid & ((id_use_rs1 & id_rs1!=0 & cnt[id_rs1]!=0) | (id_use_rs2 & id_rs2!=0 & cnt[id_rs2]!=0)).
  - The regfile write lands at the edge, so a same-cycle WB write to a source still stalls that cycle.
- Priority each cycle (combinational outputs): mem_stall > ex_redirect > raw > issue.
  - mem_stall: stall_id=stall_ex=stall_mem=1, stall_wb=0, bubble_wb=1, no issue. A redirect during mem_stall is held by EX and acted on once mem_stall drops.
  - ex_redirect: flush_id=1, bubble_ex=1, all stalls 0, no issue.
  - raw: stall_id=1, bubble_ex=1, other stalls 0, no issue.
  - else: all outputs 0; issue = id_valid.
- Scoreboard update on posedge clk:
  - inc = issue & id_en_rd & id_rd!=0.
  - dec = wb_valid & wb_en_rd & wb_rd!=0.
  - inc and dec to the same register: counter unchanged.
  - Decrement at 0 holds 0. Increment at max (3) holds 3 and fires a simulation assertion; unreachable with 3 downstream stages.
  - cnt[0] is always 0.
- stall_cycles: +1 per cycle with stall_id=1; saturates at all-ones.
- busy_any: OR over (cnt[i]!=0), combinational.
- Reset (reset=0, async):
  - All counters 0, FSM IDLE, stall_cycles 0.
  - All outputs forced 0 while reset is low.
  - Reset mid-wait discards the pending memory wait.
- Latency: all control outputs are same-cycle combinational from inputs plus registered state. Scoreboard effects are visible the cycle after the edge.

Test Plan:
- Issue add x5 (cnt[5]=1), next ID reads x5 -> stall_id=1, bubble_ex=1 for 3 cycles until WB edge writes x5; issue on 4th cycle; stall_cycles=3.
- Back-to-back writers to x7 with no readers -> cnt[7] goes 1,2, then decrements to 0 as each retires; busy_any falls after the second WB.
- mem_req=1, mem_done low 4 cycles then high -> stall_id/ex/mem=1 and bubble_wb=1 for exactly 4 cycles; FSM back to IDLE; WB never stalled.
- ex_redirect=1 coinciding with raw hazard on x3 -> flush_id=1, bubble_ex=1, stall_id=0; scoreboard unchanged.
- Same cycle: issue writing x9 and WB writing x9 with cnt[9]=1 -> cnt[9] stays 1; ID read of x0 with any state -> never stalls.
- Assert reset during WAIT with cnt[4]=2 -> all outputs 0 immediately; after release, cnt all 0, FSM IDLE, stall_cycles=0.
